// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types and helpers for the register-file slice.
//   NREG     : number of architectural registers.
//   REG_ZERO : index of the hard-wired zero register.
//   reg_idx_t: 4-bit register index.
//   reg_sel_t: 16-bit one-hot register select.
//   is_onehot16: true when exactly one select bit is set.
package mips_pkg;

  localparam int NREG     = 16;
  localparam int REG_ZERO = 0;

  typedef logic [3:0]      reg_idx_t;
  typedef logic [NREG-1:0] reg_sel_t;

  // A value with exactly one bit set is non-zero and has no bit left
  // once its lowest set bit is cleared.
  function automatic logic is_onehot16(input reg_sel_t sel);
    return (sel != '0) && ((sel & (sel - reg_sel_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Pending-write tracking for the register file and hazard detection.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     i_wr_valid     : a well-formed writeback happens this cycle
//     i_wr_sel       : one-hot writeback destination
//     i_issue_valid  : a well-formed register-writing instruction issues
//     i_issue_sel    : one-hot destination of the issuing instruction
//     i_rs, i_rt     : source register indices
//     i_rs_used/rt   : the issuing instruction reads rs / rt
//     o_stall        : combinational hazard, issue stage must hold
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_wr_valid,
  input  reg_sel_t i_wr_sel,
  input  logic     i_issue_valid,
  input  reg_sel_t i_issue_sel,
  input  reg_idx_t i_rs,
  input  reg_idx_t i_rt,
  input  logic     i_rs_used,
  input  logic     i_rt_used,
  output logic     o_stall
);

  // Bit 0 is always held at zero so that the zero register never stalls.
  reg_sel_t r_busy;
  reg_sel_t w_clr;
  reg_sel_t w_set;
  reg_sel_t w_busy_next;
  logic     w_rs_hz;
  logic     w_rt_hz;

  assign w_clr = i_wr_valid ? i_wr_sel : '0;

  // A writeback in the same cycle resolves the hazard through the bypass.
  assign w_rs_hz = i_rs_used && r_busy[i_rs] && !w_clr[i_rs];
  assign w_rt_hz = i_rt_used && r_busy[i_rt] && !w_clr[i_rt];
  assign o_stall = w_rs_hz || w_rt_hz;

  // A stalled issue has not really issued, so it must not mark anything.
  assign w_set = (i_issue_valid && !o_stall) ? i_issue_sel : '0;

  // Set is applied after clear: a new writer to the same register is still
  // outstanding even though the older one retires this cycle.
  assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~reg_sel_t'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: rtl/reg_file16.sv
// reg_file16
//   Sixteen-entry register file with write-to-read bypass, a pending-write
//   scoreboard and a sticky malformed-select flag.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     regWrite          : writeback enable
//     decOut            : one-hot writeback select
//     writeData         : writeback data
//     rs, rt            : source register indices
//     rsUsed, rtUsed    : instruction reads rs / rt
//     issueValid        : a register-writing instruction issues
//     issueDec          : one-hot destination of that instruction
//     regRs, regRt      : operand read data (combinational)
//     stall             : hazard on an outstanding write
//     decErr            : sticky malformed-select flag
module reg_file16
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  reg_sel_t          decOut,
  input  logic [DATA_W-1:0] writeData,
  input  reg_idx_t          rs,
  input  reg_idx_t          rt,
  input  logic              rsUsed,
  input  logic              rtUsed,
  input  logic              issueValid,
  input  reg_sel_t          issueDec,
  output logic [DATA_W-1:0] regRs,
  output logic [DATA_W-1:0] regRt,
  output logic              stall,
  output logic              decErr
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_dec_err;
  logic              w_wr_ok;
  logic              w_sel_err;

  assign w_wr_ok   = regWrite && is_onehot16(decOut);
  assign w_sel_err = (regWrite   && !is_onehot16(decOut)) ||
                     (issueValid && !is_onehot16(issueDec));

  // NOTE: the storage is a flop array rather than a RAM macro, so it can
  // take the asynchronous clear that guarantees zeros after reset.
  // Entry 0 is cleared and never written; it folds to a constant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 1; i < NREG; i++) begin
        if (decOut[i]) r_regs[i] <= writeData;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec_err <= 1'b0;
    end else if (w_sel_err) begin
      r_dec_err <= 1'b1;
    end
  end

  assign decErr = r_dec_err;

  // Bypass is suppressed while in reset so reads are zero throughout.
  // NOTE: each always_comb output gets a default first so no latch forms.
  always_comb begin
    regRs = '0;
    if (reset && rs != reg_idx_t'(REG_ZERO)) begin
      if (w_wr_ok && decOut[rs]) regRs = writeData;
      else                       regRs = r_regs[rs];
    end
  end

  always_comb begin
    regRt = '0;
    if (reset && rt != reg_idx_t'(REG_ZERO)) begin
      if (w_wr_ok && decOut[rt]) regRt = writeData;
      else                       regRt = r_regs[rt];
    end
  end

  // Malformed issue selects are dropped here so they never mark busy bits.
  reg_scoreboard u_scoreboard (
    .clk           (clk),
    .rst_n         (reset),
    .i_wr_valid    (w_wr_ok),
    .i_wr_sel      (decOut),
    .i_issue_valid (issueValid && is_onehot16(issueDec)),
    .i_issue_sel   (issueDec),
    .i_rs          (rs),
    .i_rt          (rt),
    .i_rs_used     (rsUsed),
    .i_rt_used     (rtUsed),
    .o_stall       (stall)
  );

endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16
//   Table-driven bench for reg_file16: each row drives one cycle of inputs
//   and carries the outputs expected in that cycle. Expected values are
//   queued when a row is driven and popped when outputs are sampled.
module tb_reg_file16;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [15:0] decOut;
  logic [31:0] writeData;
  logic [3:0]  rs, rt;
  logic        rsUsed, rtUsed;
  logic        issueValid;
  logic [15:0] issueDec;
  logic [31:0] regRs, regRt;
  logic        stall;
  logic        decErr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file16 #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .regWrite   (regWrite),
    .decOut     (decOut),
    .writeData  (writeData),
    .rs         (rs),
    .rt         (rt),
    .rsUsed     (rsUsed),
    .rtUsed     (rtUsed),
    .issueValid (issueValid),
    .issueDec   (issueDec),
    .regRs      (regRs),
    .regRt      (regRt),
    .stall      (stall),
    .decErr     (decErr)
  );

  typedef struct {
    logic        rw;
    logic [15:0] dec;
    logic [31:0] wd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        rsu;
    logic        rtu;
    logic        iv;
    logic [15:0] idec;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(logic rw, logic [15:0] dec, logic [31:0] wd,
                              logic [3:0] a, logic [3:0] b, logic rsu, logic rtu,
                              logic iv, logic [15:0] idec, logic [31:0] e_rs,
                              logic [31:0] e_rt, logic e_stall, logic e_err);
    vec_t v;
    v.rw = rw; v.dec = dec; v.wd = wd; v.rs = a; v.rt = b;
    v.rsu = rsu; v.rtu = rtu; v.iv = iv; v.idec = idec;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    regWrite = v.rw; decOut = v.dec; writeData = v.wd;
    rs = v.rs; rt = v.rt; rsUsed = v.rsu; rtUsed = v.rtu;
    issueValid = v.iv; issueDec = v.idec;
  endtask

  task automatic push_exp(input string tag, input vec_t v);
    exp_t e;
    e.tag = tag; e.rs = v.e_rs; e.rt = v.e_rt; e.stall = v.e_stall; e.err = v.e_err;
    exp_q.push_back(e);
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, " regRs"},  regRs,         e.rs);
    check({e.tag, " regRt"},  regRt,         e.rt);
    check({e.tag, " stall"},  {31'd0, stall},  {31'd0, e.stall});
    check({e.tag, " decErr"}, {31'd0, decErr}, {31'd0, e.err});
  endtask

  // Drive one row just after the rising edge, sample on the falling edge.
  task automatic apply(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    push_exp(tag, v);
    @(negedge clk);
    pop_and_check();
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 16'h0, 32'h0, 4'd0, 4'd0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0);

    // Reset held low: everything reads zero even with a would-be bypass.
    reset = 1'b0;
    drive(mk(1, 16'h0020, 32'h5555AAAA, 4'd5, 4'd5, 1, 1, 1, 16'h0020,
             32'h0, 32'h0, 0, 0));
    #12;
    push_exp("in_reset", idle);
    pop_and_check();
    drive(idle);
    @(posedge clk);
    #1 reset = 1'b1;

    //          rw dec       wd            rs  rt  rsu rtu iv idec      e_rs          e_rt         st er
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd5, 4'd0, 1, 0, 0, 16'h0000, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(1, 16'h0020, 32'hDEADBEEF, 4'd5, 4'd0, 1, 0, 0, 16'h0000, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd5, 4'd0, 1, 0, 0, 16'h0000, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16'h0001, 32'h1234,     4'd0, 4'd5, 0, 0, 0, 16'h0000, 32'h0,        32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd0, 0, 0, 0, 16'h0000, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(1, 16'h0010, 32'hCAFE0004, 4'd4, 4'd5, 0, 0, 0, 16'h0000, 32'hCAFE0004, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 16'h0030, 32'hFFFFFFFF, 4'd4, 4'd5, 0, 0, 0, 16'h0000, 32'hCAFE0004, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd4, 4'd5, 0, 0, 0, 16'h0000, 32'hCAFE0004, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 16'h0000, 32'h1,        4'd4, 4'd5, 0, 0, 0, 16'h0000, 32'hCAFE0004, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd3, 4'd0, 1, 0, 1, 16'h0008, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd3, 4'd0, 1, 0, 0, 16'h0000, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk(1, 16'h0008, 32'h33333333, 4'd3, 4'd0, 1, 0, 0, 16'h0000, 32'h33333333, 32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd3, 4'd0, 1, 0, 0, 16'h0000, 32'h33333333, 32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd7, 0, 1, 1, 16'h0080, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(1, 16'h0080, 32'h77777777, 4'd0, 4'd7, 0, 1, 1, 16'h0080, 32'h0,        32'h77777777, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd7, 0, 1, 0, 16'h0000, 32'h0,        32'h77777777, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd7, 0, 1, 1, 16'h0004, 32'h0,        32'h77777777, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd2, 4'd7, 1, 0, 0, 16'h0000, 32'h0,        32'h77777777, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd0, 0, 0, 1, 16'h0006, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd1, 4'd2, 1, 1, 0, 16'h0000, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd7, 4'd3, 0, 1, 0, 16'h0000, 32'h77777777, 32'h33333333, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd0, 4'd0, 0, 0, 1, 16'h0004, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 16'h0000, 32'h0,        4'd2, 4'd7, 1, 1, 0, 16'h0000, 32'h0,        32'h77777777, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-cycle reset pulse with busy[2] and busy[7] set.
    @(posedge clk);
    #1;
    drive(mk(0, 16'h0, 32'h0, 4'd2, 4'd5, 1, 1, 0, 16'h0, 32'h0, 32'h0, 0, 0));
    #1 reset = 1'b0;
    #1;
    push_exp("rst_pulse", mk(0, 16'h0, 32'h0, 4'd2, 4'd5, 1, 1, 0, 16'h0, 32'h0, 32'h0, 0, 0));
    pop_and_check();
    #4 reset = 1'b1;
    apply("post_rst_a", mk(0, 16'h0000, 32'h0, 4'd4, 4'd5, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 0, 0));
    apply("post_rst_b", mk(0, 16'h0000, 32'h0, 4'd2, 4'd7, 1, 1, 0, 16'h0000, 32'h0, 32'h0, 0, 0));

    // A malformed issue select alone raises decErr one cycle later.
    apply("bad_issue",  mk(0, 16'h0000, 32'h0, 4'd0, 4'd0, 0, 0, 1, 16'h0000, 32'h0, 32'h0, 0, 0));
    apply("bad_issue1", mk(0, 16'h0000, 32'h0, 4'd0, 4'd0, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 0, 1));

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
